nx_stream_arbiter: RTL
======================

# nx_stream_arbiter

- Arbitrates one priority stream and `REQUESTERS` round-robin streams onto a single registered outbound message stream.
- A bounded starvation guard stops the priority stream from locking out the other lanes.
- Sits between the device wrapper's control message source, the mesh outbound stream and any debug sources, ahead of the outbound FIFO.
- Replaces the fixed "control always wins" mux.

## Interface
- `STREAM_WIDTH`, 32: message width in bits.
- `REQUESTERS`, 4: number of round-robin lanes, legal range 2..8.
- `STARVE_LIMIT`, 8: maximum consecutive priority grants while any lane waits, legal range 1..255.
- `LANE_WIDTH`, `$clog2(REQUESTERS)`: derived, not overridable.
- `clk_i`  in  1  sole clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `prio_data_i`  in  STREAM_WIDTH  priority message.
- `prio_valid_i`  in  1  priority message present.
- `prio_ready_o`  out  1  priority message accepted this cycle.
- `req_data_i`  in  REQUESTERS*STREAM_WIDTH  lane k occupies bits [k*STREAM_WIDTH +: STREAM_WIDTH].
- `req_valid_i`  in  REQUESTERS  per-lane valid.
- `req_ready_o`  out  REQUESTERS  per-lane accept, at most one bit set.
- `out_data_o`  out  STREAM_WIDTH  registered winning message.
- `out_prio_o`  out  1  1 when the held message came from the priority input.
- `out_lane_o`  out  LANE_WIDTH  source lane of the held message; 0 when `out_prio_o` is set.
- `out_valid_o`  out  1  output register full.
- `out_ready_i`  in  1  downstream accepts the held message.

## Operation
- **Handshake.** A transfer happens on any input or output when valid and ready are both high at a rising edge. Upstream holds valid and data stable until accepted. `*_ready_o` are combinational from valids and state.
- **Output register.**
  - `load = !out_valid_o || out_ready_i`.
  - On load, the winner is captured into `out_data_o`, `out_prio_o` and `out_lane_o`, and `out_valid_o` is set to 1.
  - If no input is valid, `out_valid_o` is cleared, but only when the held message is consumed.
- **Winner selection** (only when `load`):
  1. If `prio_valid_i` and `starve_cnt < STARVE_LIMIT`, the priority input wins.
  2. Else the first set `req_valid_i` bit, searching from `rr_ptr` upward modulo REQUESTERS, wins.
  3. Else if `prio_valid_i`, the priority input wins. This covers the limit being reached with no lane valid.
  4. Else there is no grant.
- **Ready outputs.** `prio_ready_o` or `req_ready_o[k]` is high only in the cycle its source wins. All readies are 0 while `rst_i` is high.
- **`rr_ptr`** (LANE_WIDTH bits, reset 0):
  - After a lane-k grant it becomes `(k+1) mod REQUESTERS`.
  - It is unchanged on priority grants and idle cycles.
- **`starve_cnt`** (8 bits, reset 0):
  - Increments on a priority grant while any `req_valid_i` bit is set, saturating at STARVE_LIMIT.
  - Clears on any lane grant.
  - Clears on any cycle with `req_valid_i == 0`.
- **Boundary cases.**
  - Output full and `out_ready_i` low: no grants, all state frozen, the held message stays stable.
  - Priority and every lane valid simultaneously: exactly one grant per cycle.
  - Reset mid-transfer: the held message is dropped; upstream sees no accept for it.

## Timing
- Reset values: `out_valid_o` 0, `out_data_o` 0, `out_prio_o` 0, `out_lane_o` 0, `prio_ready_o` 0, `req_ready_o` 0.
- Latency: a message accepted at edge N is visible on `out_*` after edge N, i.e. one cycle.
- Throughput: one message per cycle with `out_ready_i` held high. There are no bubbles between back-to-back grants.
- Fairness bound: with priority saturated, a waiting lane is granted within STARVE_LIMIT+1 grants. With all lanes saturated, each lane is granted once every REQUESTERS lane grants.
- Combinational paths: `out_ready_i`/`*_valid_i` to `*_ready_o`. There is no combinational path from inputs to `out_*`.
- `rst_i` assertion clears all registers immediately, without waiting for a clock edge. Deassertion takes effect at the next rising edge.

## Test plan
- **Reset.** Pulse `rst_i` with all valids high → all outputs 0 during reset; first grant at the first edge after release is priority (`starve_cnt` 0).
- **Single lane.** Lane 2 presents 0xA5A50002, `out_ready_i`=1 → `req_ready_o`=4'b0100 for one cycle; next cycle `out_data_o`=0xA5A50002, `out_lane_o`=2, `out_prio_o`=0.
- **Round robin.** All four lanes valid continuously, no priority, `out_ready_i`=1 → output lanes 0,1,2,3,0,1… with one message per cycle and no gaps.
- **Starvation guard.** Priority and lane 1 valid continuously, STARVE_LIMIT=8 → 8 priority messages, 1 lane-1 message, 8 priority messages, repeating.
- **Backpressure.** Output full, `out_ready_i`=0 for 5 cycles with lanes 0 and 3 valid → all readies 0 and `out_data_o` stable. On release, lanes 0 and 3 are delivered in order, with no loss or duplication.
- **Reset mid-stream.** Assert `rst_i` while `out_valid_o`=1 holding a lane-3 message → `out_valid_o` is 0 before the next edge. After release, `rr_ptr` restarts at 0: lane 0 is granted before lane 3.

Source files
------------

// File: rtl/nx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nx_stream_arbiter
// Description : Priority stream plus round-robin lanes onto one registered
//               outbound stream, with a bounded starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module nx_stream_arbiter #(
    parameter  int STREAM_WIDTH = 32,
    parameter  int REQUESTERS   = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int LANE_WIDTH   = $clog2(REQUESTERS)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [STREAM_WIDTH-1:0]            prio_data_i,
    input  logic                               prio_valid_i,
    output logic                               prio_ready_o,
    input  logic [REQUESTERS*STREAM_WIDTH-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]              req_valid_i,
    output logic [REQUESTERS-1:0]              req_ready_o,
    output logic [STREAM_WIDTH-1:0]            out_data_o,
    output logic                               out_prio_o,
    output logic [LANE_WIDTH-1:0]              out_lane_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i
);

    localparam logic [7:0]            c_starve_limit = 8'(STARVE_LIMIT);
    localparam logic [LANE_WIDTH:0]   c_req_count    = (LANE_WIDTH+1)'(REQUESTERS);
    localparam logic [LANE_WIDTH-1:0] c_last_lane    = LANE_WIDTH'(REQUESTERS-1);

    logic [STREAM_WIDTH-1:0]   r_out_data;
    logic                      r_out_prio;
    logic [LANE_WIDTH-1:0]     r_out_lane;
    logic                      r_out_valid;
    logic [LANE_WIDTH-1:0]     r_rr_ptr;
    logic [7:0]                r_starve_cnt;

    logic [STREAM_WIDTH-1:0]   w_lane_data [REQUESTERS];
    logic [2*REQUESTERS-1:0]   w_req_dbl;
    logic [REQUESTERS-1:0]     w_req_rot;
    logic                      w_lane_hit;
    logic [LANE_WIDTH-1:0]     w_lane_sel;
    logic [LANE_WIDTH:0]       w_lane_sum;
    logic [LANE_WIDTH-1:0]     w_rr_next;
    logic                      w_load;
    logic                      w_any_req;
    logic                      w_prio_first;
    logic                      w_grant_prio;
    logic                      w_grant_lane;

    genvar g;
    generate
        for (g = 0; g < REQUESTERS; g++) begin : g_lane_data
            assign w_lane_data[g] = req_data_i[g*STREAM_WIDTH +: STREAM_WIDTH];
        end
    endgenerate

    // Rotate the valids so the search always starts at bit 0 = rr_ptr.
    assign w_req_dbl = {req_valid_i, req_valid_i};
    assign w_req_rot = REQUESTERS'(w_req_dbl >> r_rr_ptr);

    always_comb begin
        w_lane_hit = 1'b0;
        w_lane_sel = '0;
        w_lane_sum = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!w_lane_hit && w_req_rot[i]) begin
                w_lane_hit = 1'b1;
                w_lane_sum = {1'b0, r_rr_ptr} + (LANE_WIDTH+1)'(i);
                if (w_lane_sum >= c_req_count) begin
                    w_lane_sel = LANE_WIDTH'(w_lane_sum - c_req_count);
                end else begin
                    w_lane_sel = LANE_WIDTH'(w_lane_sum);
                end
            end
        end
    end

    assign w_load       = !r_out_valid || out_ready_i;
    assign w_any_req    = |req_valid_i;
    assign w_prio_first = prio_valid_i && (r_starve_cnt < c_starve_limit);
    assign w_grant_prio = w_load && (w_prio_first || (!w_lane_hit && prio_valid_i));
    assign w_grant_lane = w_load && w_lane_hit && !w_prio_first;
    assign w_rr_next    = (w_lane_sel == c_last_lane) ? '0 : w_lane_sel + LANE_WIDTH'(1);

    assign prio_ready_o = !rst_i && w_grant_prio;
    assign req_ready_o  = (!rst_i && w_grant_lane) ? (REQUESTERS'(1) << w_lane_sel) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_data   <= '0;
            r_out_prio   <= 1'b0;
            r_out_lane   <= '0;
            r_out_valid  <= 1'b0;
            r_rr_ptr     <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_grant_prio || w_grant_lane;
                if (w_grant_prio) begin
                    r_out_data <= prio_data_i;
                    r_out_prio <= 1'b1;
                    r_out_lane <= '0;
                end else if (w_grant_lane) begin
                    r_out_data <= w_lane_data[w_lane_sel];
                    r_out_prio <= 1'b0;
                    r_out_lane <= w_lane_sel;
                    r_rr_ptr   <= w_rr_next;
                end
            end
            // Only priority wins taken while a lane is waiting count toward the guard.
            if (!w_any_req || w_grant_lane) begin
                r_starve_cnt <= '0;
            end else if (w_grant_prio && (r_starve_cnt < c_starve_limit)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    assign out_data_o  = r_out_data;
    assign out_prio_o  = r_out_prio;
    assign out_lane_o  = r_out_lane;
    assign out_valid_o = r_out_valid;

endmodule
`default_nettype wire
